// File: rtl/dmux4way16_ctrl_if.sv
// Handshake bundle between the producer, the DMux4Way16 datapath and its four consumers.
interface dmux4way16_ctrl_if #(
  parameter int unsigned CW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic [1:0]    in_dest;
  logic [15:0]   dmux_in;
  logic [1:0]    dmux_sel;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [CW-1:0] fifo_count;

  modport master (
    output in_valid, in_data, in_dest, out_ready,
    input  in_ready, dmux_in, dmux_sel, out_valid, fifo_count
  );

  modport slave (
    input  in_valid, in_data, in_dest, out_ready,
    output in_ready, dmux_in, dmux_sel, out_valid, fifo_count
  );
endinterface

// File: rtl/dmux4way16_ctrl.sv
// FIFO-buffered flow controller feeding DMux4Way16 with a registered one-hot output stage.
// Optional round-robin routing enabled by macro DMUX4WAY16_CTRL_RR_EN (adds rr_mode port).
module dmux4way16_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic clk,
  input  logic rst_n,
`ifdef DMUX4WAY16_CTRL_RR_EN
  input  logic rr_mode,
`endif
  dmux4way16_ctrl_if.slave bus
);
  localparam int unsigned AW = CW - 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state;
  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    odest;
  logic [15:0]   odata;
  logic [17:0]   head;
  logic [1:0]    pop_dest;
  logic          ov, fifo_empty, push, pop, transfer;

  assign ov         = (state == FULL);
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign push       = bus.in_valid && bus.in_ready;
  assign transfer   = ov && bus.out_ready[odest];
  // Reload happens in the same cycle as a transfer, giving one word per cycle.
  assign pop        = !fifo_empty && (!ov || transfer);

`ifdef DMUX4WAY16_CTRL_RR_EN
  logic [1:0] rr_ptr;

  assign pop_dest = rr_mode ? rr_ptr : head[17:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (pop && rr_mode) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end
`else
  assign pop_dest = head[17:16];
`endif

  assign bus.in_ready   = (count != CW'(DEPTH));
  assign bus.fifo_count = count;
  assign bus.dmux_sel   = odest;
  assign bus.dmux_in    = ov ? odata : '0;
  assign bus.out_valid  = ov ? (4'd1 << odest) : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_dest, bus.in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      odest <= '0;
      odata <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (pop) begin
            state <= FULL;
            odest <= pop_dest;
            odata <= head[15:0];
          end
        end
        FULL: begin
          if (pop) begin
            odest <= pop_dest;
            odata <= head[15:0];
          end else if (transfer) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_dmux4way16_ctrl.sv
// Directed self-checking bench for dmux4way16_ctrl; round-robin test runs when DMUX4WAY16_CTRL_RR_EN is defined.
module tb_dmux4way16_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
`ifdef DMUX4WAY16_CTRL_RR_EN
  logic rr_mode;
`endif

  dmux4way16_ctrl_if #(.CW(3)) bus ();

  dmux4way16_ctrl #(.DEPTH(4), .CW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef DMUX4WAY16_CTRL_RR_EN
    .rr_mode (rr_mode),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 4'b0000) begin bad++; $display("FAIL rst_out_valid got=%b exp=0000", bus.out_valid); end
    total++; if (bus.dmux_sel !== 2'd0) begin bad++; $display("FAIL rst_dmux_sel got=%0d exp=0", bus.dmux_sel); end
    total++; if (bus.dmux_in !== 16'h0000) begin bad++; $display("FAIL rst_dmux_in got=%h exp=0000", bus.dmux_in); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL rst_fifo_count got=%0d exp=0", bus.fifo_count); end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0700 + 16'(i);
      bus.in_dest  = 2'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    total++; if (bus.fifo_count !== 3'd3) begin bad++; $display("FAIL midrst_pre_count got=%0d exp=3", bus.fifo_count); end
    total++; if (bus.out_valid !== 4'b0001) begin bad++; $display("FAIL midrst_pre_valid got=%b exp=0001", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 4'b0000) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0000", bus.out_valid); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL midrst_fifo_count got=%0d exp=0", bus.fifo_count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.dmux_in !== 16'h0000) begin bad++; $display("FAIL midrst_dmux_in got=%h exp=0000", bus.dmux_in); end
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (bus.out_valid !== 4'b0000) begin bad++; $display("FAIL midrst_after_valid got=%b exp=0000", bus.out_valid); end
  endtask

  task automatic test_single();
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1234;
    bus.in_dest   = 2'd2;
    tick();
    bus.in_valid  = 1'b0;
    total++; if (bus.out_valid !== 4'b0000) begin bad++; $display("FAIL single_edgeN_valid got=%b exp=0000", bus.out_valid); end
    total++; if (bus.fifo_count !== 3'd1) begin bad++; $display("FAIL single_edgeN_count got=%0d exp=1", bus.fifo_count); end
    tick();
    total++; if (bus.out_valid !== 4'b0100) begin bad++; $display("FAIL single_valid got=%b exp=0100", bus.out_valid); end
    total++; if (bus.dmux_sel !== 2'd2) begin bad++; $display("FAIL single_sel got=%0d exp=2", bus.dmux_sel); end
    total++; if (bus.dmux_in !== 16'h1234) begin bad++; $display("FAIL single_data got=%h exp=1234", bus.dmux_in); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL single_count got=%0d exp=0", bus.fifo_count); end
    tick();
    total++; if (bus.out_valid !== 4'b0000) begin bad++; $display("FAIL single_done_valid got=%b exp=0000", bus.out_valid); end
    total++; if (bus.dmux_in !== 16'h0000) begin bad++; $display("FAIL single_done_data got=%h exp=0000", bus.dmux_in); end
  endtask

  task automatic test_full();
    logic [1:0] dests [6];
    int accepted;
    dests = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    accepted = 0;
    bus.out_ready = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0100 + 16'(i);
      bus.in_dest  = dests[i];
      if (bus.in_ready === 1'b1) accepted++;
      tick();
    end
    bus.in_valid = 1'b0;
    total++; if (accepted != 5) begin bad++; $display("FAIL full_accepted got=%0d exp=5", accepted); end
    total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", bus.fifo_count); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.out_valid !== (4'd1 << dests[i])) begin bad++; $display("FAIL drain_valid[%0d] got=%b exp=%b", i, bus.out_valid, 4'd1 << dests[i]); end
      total++; if (bus.dmux_in !== 16'h0100 + 16'(i)) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, bus.dmux_in, 16'h0100 + 16'(i)); end
      tick();
      if (i == 0) begin
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL drain_in_ready got=%b exp=1", bus.in_ready); end
      end
    end
    total++; if (bus.out_valid !== 4'b0000) begin bad++; $display("FAIL drain_end_valid got=%b exp=0000", bus.out_valid); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL drain_end_count got=%0d exp=0", bus.fifo_count); end
  endtask

  task automatic test_stall();
    bus.out_ready = 4'b1101;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h5A5A;
    bus.in_dest   = 2'd1;
    tick();
    bus.in_valid  = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.out_valid !== 4'b0010) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=0010", i, bus.out_valid); end
      total++; if (bus.dmux_in !== 16'h5A5A) begin bad++; $display("FAIL stall_data[%0d] got=%h exp=5a5a", i, bus.dmux_in); end
      tick();
    end
    bus.out_ready = 4'b1111;
    #1;
    total++; if (bus.out_valid !== 4'b0010) begin bad++; $display("FAIL stall_release_valid got=%b exp=0010", bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 4'b0000) begin bad++; $display("FAIL stall_transfer got=%b exp=0000", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 4'b1111;
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hC000 + 16'(k - 1);
        bus.in_dest  = 2'(k - 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      total++; if (bus.fifo_count > 3'd1) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp<=1", k, bus.fifo_count); end
      if (k >= 2) begin
        total++; if (bus.dmux_in !== 16'hC000 + 16'(k - 2)) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, bus.dmux_in, 16'hC000 + 16'(k - 2)); end
        total++; if (bus.out_valid !== (4'd1 << 2'(k - 2))) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", k, bus.out_valid, 4'd1 << 2'(k - 2)); end
      end
    end
    tick();
    total++; if (bus.out_valid !== 4'b0000) begin bad++; $display("FAIL b2b_end_valid got=%b exp=0000", bus.out_valid); end
  endtask

`ifdef DMUX4WAY16_CTRL_RR_EN
  task automatic test_round_robin();
    logic [1:0] exp_sel [5];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_mode = 1'b1;
    bus.out_ready = 4'b1111;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 5) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h00A0 + 16'(k - 1);
        bus.in_dest  = 2'd3;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (k >= 2) begin
        total++; if (bus.dmux_sel !== exp_sel[k - 2]) begin bad++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", k, bus.dmux_sel, exp_sel[k - 2]); end
        total++; if (bus.dmux_in !== 16'h00A0 + 16'(k - 2)) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, bus.dmux_in, 16'h00A0 + 16'(k - 2)); end
      end
    end
    rr_mode      = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h00B0;
    bus.in_dest  = 2'd3;
    tick();
    bus.in_valid = 1'b0;
    tick();
    total++; if (bus.dmux_sel !== 2'd3) begin bad++; $display("FAIL rr_off_sel got=%0d exp=3", bus.dmux_sel); end
    total++; if (bus.out_valid !== 4'b1000) begin bad++; $display("FAIL rr_off_valid got=%b exp=1000", bus.out_valid); end
    total++; if (bus.dmux_in !== 16'h00B0) begin bad++; $display("FAIL rr_off_data got=%h exp=00b0", bus.dmux_in); end
    tick();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_dest   = '0;
    bus.out_ready = '0;
`ifdef DMUX4WAY16_CTRL_RR_EN
    rr_mode = 1'b0;
`endif
    #2;
    test_reset();
    tick();
    rst_n = 1'b1;
    tick();
    test_mid_reset();
    test_single();
    test_full();
    test_stall();
    test_back_to_back();
`ifdef DMUX4WAY16_CTRL_RR_EN
    test_round_robin();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
